// File: rtl/mul_tree_pipe.sv
// Pipelined unsigned product of NUM_OPS operands via a balanced binary tree,
// with valid/ready stall, tag sideband, scaled output and saturation.

module mul_tree_node #(
  parameter int W = 20
) (
  input  logic           clk,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  localparam int H  = (W + 1) / 2;
  localparam int HW = W - H;

  logic [2*H-1:0]  ll_d, ll_q;
  logic [W-1:0]    hl_d, hl_q, lh_d, lh_q;
  logic [2*HW-1:0] hh_d, hh_q;
  logic [2*W-1:0]  p_d, p_q;

  // Cycle A: four half-width partial products; cycle B: recombine exactly.
  always_comb begin
    ll_d = (2*H)'(a[H-1:0]) * (2*H)'(b[H-1:0]);
    hl_d = W'(a[W-1:H]) * W'(b[H-1:0]);
    lh_d = W'(a[H-1:0]) * W'(b[W-1:H]);
    hh_d = (2*HW)'(a[W-1:H]) * (2*HW)'(b[W-1:H]);
    p_d  = ((2*W)'(hh_q) << (2*H)) + (((2*W)'(hl_q) + (2*W)'(lh_q)) << H)
         + (2*W)'(ll_q);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      ll_q <= ll_d;
      hl_q <= hl_d;
      lh_q <= lh_d;
      hh_q <= hh_d;
      p_q  <= p_d;
    end
  end

  assign p = p_q;
endmodule

module mul_tree_pipe #(
  parameter int NUM_OPS   = 4,
  parameter int DATA_W    = 10,
  parameter int OUT_W     = 40,
  parameter int OUT_SHIFT = 0,
  parameter int ROUND     = 0,
  parameter int TAG_W     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_OPS*DATA_W-1:0]   in_ops,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_result,
  output logic                        out_sat,
  output logic [TAG_W-1:0]            out_tag
);
  localparam int L      = $clog2(NUM_OPS);
  localparam int STAGES = 2 * L;
  localparam int FULL_W = NUM_OPS * DATA_W;
  localparam int PW     = 2 * DATA_W;
  localparam int RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam int SAT_SH = (OUT_W > FULL_W) ? FULL_W : OUT_W;
  localparam logic [FULL_W:0] RND =
    (ROUND != 0 && OUT_SHIFT > 0) ? ((FULL_W+1)'(1) << RSH) : '0;

  logic                             stall, en;
  logic [STAGES:1]                  vld_pipe_d, vld_pipe_q;
  logic [STAGES-1:1][TAG_W-1:0]     tag_pipe_d, tag_pipe_q;
  logic [L:1][FULL_W-1:0]           tree;
  logic [NUM_OPS/2-1:0][PW-1:0]     l1_d, l1_q;
  logic [FULL_W:0]                  scaled;
  logic                             sat;
  logic [OUT_W-1:0]                 out_result_d, out_result_q;
  logic                             out_sat_d, out_sat_q;
  logic [TAG_W-1:0]                 out_tag_d, out_tag_q;

  assign stall    = vld_pipe_q[STAGES] && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  always_comb begin
    vld_pipe_d    = {vld_pipe_q[STAGES-1:1], in_valid};
    tag_pipe_d    = tag_pipe_q;
    tag_pipe_d[1] = in_tag;
    for (int k = 2; k < STAGES; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
    for (int n = 0; n < NUM_OPS/2; n++)
      l1_d[n] = PW'(in_ops[2*n*DATA_W +: DATA_W]) * PW'(in_ops[(2*n+1)*DATA_W +: DATA_W]);
  end

  assign tree[1] = l1_q;

  for (genvar g = 2; g <= L; g++) begin : g_lvl
    localparam int W = DATA_W << (g - 1);
    for (genvar n = 0; n < (NUM_OPS >> g); n++) begin : g_node
      mul_tree_node #(.W(W)) u_node (
        .clk (clk),
        .en  (en),
        .a   (tree[g-1][2*n*W +: W]),
        .b   (tree[g-1][(2*n+1)*W +: W]),
        .p   (tree[g][2*n*W +: 2*W])
      );
    end
  end

  // Output regs only load on a valid slot so they hold across bubbles.
  always_comb begin
    scaled       = ({1'b0, tree[L]} + RND) >> OUT_SHIFT;
    sat          = |(scaled >> SAT_SH);
    out_result_d = out_result_q;
    out_sat_d    = out_sat_q;
    out_tag_d    = out_tag_q;
    if (vld_pipe_q[STAGES-1]) begin
      out_result_d = sat ? '1 : OUT_W'(scaled);
      out_sat_d    = sat;
      out_tag_d    = tag_pipe_q[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
      out_tag_q    <= '0;
    end else if (en) begin
      vld_pipe_q   <= vld_pipe_d;
      out_result_q <= out_result_d;
      out_sat_q    <= out_sat_d;
      out_tag_q    <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_pipe_q <= tag_pipe_d;
      l1_q       <= l1_d;
    end
  end

  assign out_valid  = vld_pipe_q[STAGES];
  assign out_result = out_result_q;
  assign out_sat    = out_sat_q;
  assign out_tag    = out_tag_q;
endmodule

// File: tb/tb_mul_tree_pipe.sv
// Scoreboard bench: four 4x10 configurations share one input bus, plus an
// 8x8 instance; monitors pop expected results whenever a DUT hands one out.

module tb_mul_tree_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [39:0] in_ops   = '0;
  logic [2:0]  in_tag   = '0;
  logic        out_ready = 1'b1;

  logic a_ir, a_ov, a_sat, b_ir, b_ov, b_sat, c_ir, c_ov, c_sat, d_ir, d_ov, d_sat;
  logic [39:0] a_res, b_res, c_res;
  logic [15:0] d_res;
  logic [2:0]  a_tag, b_tag, c_tag, d_tag;

  logic        e_iv = 1'b0, e_or = 1'b1, e_ir, e_ov, e_sat;
  logic [63:0] e_ops = '0, e_res;
  logic [3:0]  e_itag = '0, e_tag;

  mul_tree_pipe #(.TAG_W(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_ops(in_ops),
    .in_tag(in_tag), .out_valid(a_ov), .out_ready(out_ready), .out_result(a_res),
    .out_sat(a_sat), .out_tag(a_tag));
  mul_tree_pipe #(.OUT_SHIFT(10), .ROUND(0), .TAG_W(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_ops(in_ops),
    .in_tag(in_tag), .out_valid(b_ov), .out_ready(out_ready), .out_result(b_res),
    .out_sat(b_sat), .out_tag(b_tag));
  mul_tree_pipe #(.OUT_SHIFT(10), .ROUND(1), .TAG_W(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_ops(in_ops),
    .in_tag(in_tag), .out_valid(c_ov), .out_ready(out_ready), .out_result(c_res),
    .out_sat(c_sat), .out_tag(c_tag));
  mul_tree_pipe #(.OUT_W(16), .TAG_W(3)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir), .in_ops(in_ops),
    .in_tag(in_tag), .out_valid(d_ov), .out_ready(out_ready), .out_result(d_res),
    .out_sat(d_sat), .out_tag(d_tag));
  mul_tree_pipe #(.NUM_OPS(8), .DATA_W(8), .OUT_W(64), .TAG_W(4)) u_e (
    .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .in_ops(e_ops),
    .in_tag(e_itag), .out_valid(e_ov), .out_ready(e_or), .out_result(e_res),
    .out_sat(e_sat), .out_tag(e_tag));

  typedef struct {
    logic [63:0] res;
    logic        sat;
    logic [3:0]  tag;
    int          lat;
    int          t0;
  } exp_t;
  exp_t qa[$], qb[$], qc[$], qd[$], qe[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed vectors: op k = vops[i][k]; ea..ed expected per configuration.
  logic [9:0]  vops [8][4] = '{'{1023,1023,1023,1023}, '{2,3,16,16}, '{3,5,7,11},
                               '{15,15,15,15}, '{0,1023,1023,1023}, '{1,1,1,1},
                               '{256,256,1,1}, '{255,257,1,1}};
  logic [63:0] ea [8] = '{64'd1095222947841, 64'd1536, 64'd1155, 64'd50625,
                          64'd0, 64'd1, 64'd65536, 64'd65535};
  logic [63:0] eb [8] = '{64'd1069553660, 64'd1, 64'd1, 64'd49, 64'd0, 64'd0, 64'd64, 64'd63};
  logic [63:0] ec [8] = '{64'd1069553660, 64'd2, 64'd1, 64'd49, 64'd0, 64'd0, 64'd64, 64'd64};
  logic [63:0] ed [8] = '{64'd65535, 64'd1536, 64'd1155, 64'd50625, 64'd0, 64'd1,
                          64'd65535, 64'd65535};
  logic        sd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: out_valid with no pending result (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) if (!rst && a_ov && out_ready) begin
    exp_t e;
    if (qa.size() == 0) unexp("a_unexpected");
    else begin
      e = qa.pop_front();
      chk("a_res", 64'(a_res), e.res); chk("a_sat", 64'(a_sat), 64'(e.sat));
      chk("a_tag", 64'(a_tag), 64'(e.tag));
      if (e.lat > 0) chk("a_latency", 64'(cyc - e.t0), 64'(e.lat));
    end
  end
  always @(negedge clk) if (!rst && b_ov && out_ready) begin
    exp_t e;
    if (qb.size() == 0) unexp("b_unexpected");
    else begin
      e = qb.pop_front();
      chk("b_res", 64'(b_res), e.res); chk("b_sat", 64'(b_sat), 64'(e.sat));
      chk("b_tag", 64'(b_tag), 64'(e.tag));
    end
  end
  always @(negedge clk) if (!rst && c_ov && out_ready) begin
    exp_t e;
    if (qc.size() == 0) unexp("c_unexpected");
    else begin
      e = qc.pop_front();
      chk("c_res", 64'(c_res), e.res); chk("c_sat", 64'(c_sat), 64'(e.sat));
      chk("c_tag", 64'(c_tag), 64'(e.tag));
    end
  end
  always @(negedge clk) if (!rst && d_ov && out_ready) begin
    exp_t e;
    if (qd.size() == 0) unexp("d_unexpected");
    else begin
      e = qd.pop_front();
      chk("d_res", 64'(d_res), e.res); chk("d_sat", 64'(d_sat), 64'(e.sat));
      chk("d_tag", 64'(d_tag), 64'(e.tag));
    end
  end
  always @(negedge clk) if (!rst && e_ov) begin
    exp_t e;
    if (qe.size() == 0) unexp("e_unexpected");
    else begin
      e = qe.pop_front();
      chk("e_res", e_res, e.res); chk("e_sat", 64'(e_sat), 64'(e.sat));
      chk("e_tag", 64'(e_tag), 64'(e.tag));
      chk("e_latency", 64'(cyc - e.t0), 64'(e.lat));
    end
  end

  // Flow-control watch on instance A: in_ready tracks stall, outputs freeze while stalled.
  logic        p_stall = 1'b0, p_sat = 1'b0;
  logic [39:0] p_res = '0;
  logic [2:0]  p_tag = '0;
  always @(negedge clk) begin
    chk("in_ready", 64'(a_ir), 64'(!(a_ov && !out_ready)));
    if (p_stall) begin
      chk("hold_valid", 64'(a_ov), 64'd1);
      chk("hold_res", 64'(a_res), 64'(p_res));
      chk("hold_sat", 64'(a_sat), 64'(p_sat));
      chk("hold_tag", 64'(a_tag), 64'(p_tag));
    end
    p_stall <= !rst && a_ov && !out_ready;
    p_res   <= a_res;
    p_sat   <= a_sat;
    p_tag   <= a_tag;
  end

  task automatic send(input int i, input logic [2:0] tag, input int lat, input bit push);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_tag   = tag;
    for (int k = 0; k < 4; k++) in_ops[k*10 +: 10] = vops[i][k];
    @(negedge clk);
    while (!(a_ir && b_ir && c_ir && d_ir) && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for vector %0d", i);
    end else if (push) begin
      e.tag = 4'(tag); e.lat = lat; e.t0 = cyc;
      e.sat = 1'b0; e.res = ea[i]; qa.push_back(e);
      e.res = eb[i]; qb.push_back(e);
      e.res = ec[i]; qc.push_back(e);
      e.sat = sd[i]; e.res = ed[i]; qd.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] prod8(input logic [63:0] ops);
    logic [63:0] p = 64'd1;
    for (int k = 0; k < 8; k++) p = p * 64'(ops[k*8 +: 8]);
    return p;
  endfunction

  task automatic send_e(input logic [63:0] ops, input logic [3:0] tag, input logic [63:0] exp);
    int   n = 0;
    exp_t e;
    e_iv = 1'b1; e_ops = ops; e_itag = tag;
    @(negedge clk);
    while (!e_ir && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL e_send_timeout: in_ready stayed 0");
    end else begin
      e.res = exp; e.sat = 1'b0; e.tag = tag; e.lat = 6; e.t0 = cyc;
      qe.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    e_iv     = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size() + qe.size()) != 0 && n < 200) begin
      n++; @(negedge clk);
    end
    chk("drain_pending", 64'(qa.size() + qb.size() + qc.size() + qd.size() + qe.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_start;
    logic [63:0] r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_out_result", 64'(a_res), 64'd0);
    chk("rst_out_sat", 64'(a_sat), 64'd0);
    chk("rst_out_tag", 64'(a_tag), 64'd0);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    chk("rst_e_out_valid", 64'(e_ov), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single full-scale bundle, latency 4.
    send(0, 3'd1, 4, 1'b1);
    idle();
    drain();

    // Back-to-back: one bundle per cycle, each still latency 4.
    t_start = cyc;
    for (int i = 0; i < 8; i++) send(i, 3'(i), 4, 1'b1);
    chk("b2b_accept_cycles", 64'(cyc - t_start), 64'd8);
    idle();
    drain();

    // Stream with 3-cycle downstream stall after first result.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 3'(i), 0, 1'b1);
        idle();
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!a_ov && n < 100) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three bundles in flight: none may emerge.
    send(1, 3'd5, 0, 1'b0);
    send(2, 3'd6, 0, 1'b0);
    send(3, 3'd7, 0, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(a_ir), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(a_ov), 64'd0);
      chk("flush_out_result", 64'(a_res), 64'd0);
    end
    @(posedge clk); #1;
    send(0, 3'd1, 4, 1'b1);
    idle();
    drain();

    // 8x8 instance: directed then random operands, latency 6.
    send_e({8{8'hff}}, 4'd1, 64'd17878103347812890625);
    send_e(64'h0807060504030201, 4'd2, 64'd40320);
    send_e(64'hFFFF_FFFF_FFFF_00FF, 4'd3, 64'd0);
    for (int k = 0; k < 6; k++) begin
      r = {$urandom, $urandom};
      if (k == 1) r[15:8] = 8'd0;
      if (k == 2) r[39:32] = 8'hff;
      send_e(r, 4'(k + 4), prod8(r));
    end
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
